// File: rtl/vdp_blend_stage_if.sv
// Pixel, palette-write and RGB-output signal bundle for vdp_blend_stage.
// The master side drives pixels and palette writes; the slave side is the blend stage.
interface vdp_blend_stage_if;
  logic        pixel_valid;
  logic [7:0]  prioritized_pixel;
  logic [4:0]  prioritized_layer;
  logic [7:0]  prioritized_masked_pixel;
  logic [4:0]  prioritized_masked_layer;
  logic        blend_enable;
  logic        palette_write_en;
  logic [7:0]  palette_write_address;
  logic [15:0] palette_write_data;
  logic        rgb_valid;
  logic [11:0] rgb;

  modport master (
    output pixel_valid, prioritized_pixel, prioritized_layer,
           prioritized_masked_pixel, prioritized_masked_layer, blend_enable,
           palette_write_en, palette_write_address, palette_write_data,
    input  rgb_valid, rgb
  );

  modport slave (
    input  pixel_valid, prioritized_pixel, prioritized_layer,
           prioritized_masked_pixel, prioritized_masked_layer, blend_enable,
           palette_write_en, palette_write_address, palette_write_data,
    output rgb_valid, rgb
  );
endinterface

// File: rtl/vdp_blend_stage.sv
// Palette lookup and alpha-over blend stage: index in, RGB444 out, four-stage pipe.
// Owns the dual-copy palette RAM and its host write port.
module vdp_blend_stage (
  input  logic               clk,
  input  logic               reset_n,
  vdp_blend_stage_if.slave   bus
);

  // Blend one 4-bit channel: (p*(16-a) + m*a) >> 4; the sum never exceeds 240.
  function automatic logic [3:0] blend_ch(input logic [3:0] p, input logic [3:0] m,
                                          input logic [3:0] a);
    logic [8:0] w_sum;
    w_sum = 9'(p) * (9'd16 - 9'(a)) + 9'(m) * 9'(a);
    return w_sum[7:4];
  endfunction

  // The primary copy keeps RGB only: primary alpha never reaches the blend.
  logic [11:0] r_pal_prim [256];
  logic [15:0] r_pal_mask [256];

  logic        r_s0_valid;
  logic        r_s0_blend;
  logic [7:0]  r_s0_paddr;
  logic [7:0]  r_s0_maddr;
  logic        r_s1_valid;
  logic        r_s1_blend;
  logic [11:0] r_s1_prim;
  logic [15:0] r_s1_mask;
  logic        r_s2_valid;
  logic [11:0] r_s2_rgb;
  logic        r_s3_valid;
  logic [11:0] r_s3_rgb;
  logic [11:0] w_blend_rgb;

  // S0: latch the resolved pixel; a primary layer of 0 selects the backdrop entry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s0_valid <= 1'b0;
      r_s0_blend <= 1'b0;
      r_s0_paddr <= 8'd0;
      r_s0_maddr <= 8'd0;
    end else begin
      r_s0_valid <= bus.pixel_valid;
      r_s0_blend <= bus.blend_enable & (bus.prioritized_masked_layer != 5'd0);
      r_s0_paddr <= (bus.prioritized_layer != 5'd0) ? bus.prioritized_pixel : 8'd0;
      r_s0_maddr <= bus.prioritized_masked_pixel;
    end
  end

  // Palette RAM: host write to both copies, read-before-write on same-address collision.
  always_ff @(posedge clk) begin
    if (bus.palette_write_en) begin
      r_pal_prim[bus.palette_write_address] <= bus.palette_write_data[11:0];
      r_pal_mask[bus.palette_write_address] <= bus.palette_write_data;
    end
    r_s1_prim <= r_pal_prim[r_s0_paddr];
    r_s1_mask <= r_pal_mask[r_s0_maddr];
  end

  // S1 control delayed alongside the palette read data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1_valid <= 1'b0;
      r_s1_blend <= 1'b0;
    end else begin
      r_s1_valid <= r_s0_valid;
      r_s1_blend <= r_s0_blend;
    end
  end

  // S2 blend arithmetic; without alpha-over the primary colour passes unchanged.
  always_comb begin
    w_blend_rgb = r_s1_prim;
    if (r_s1_blend) begin
      w_blend_rgb = {blend_ch(r_s1_prim[11:8], r_s1_mask[11:8], r_s1_mask[15:12]),
                     blend_ch(r_s1_prim[7:4],  r_s1_mask[7:4],  r_s1_mask[15:12]),
                     blend_ch(r_s1_prim[3:0],  r_s1_mask[3:0],  r_s1_mask[15:12])};
    end else begin
      w_blend_rgb = r_s1_prim;
    end
  end

  // S2 and S3 registers; invalid pixels still carry their computed colour.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s2_valid <= 1'b0;
      r_s2_rgb   <= 12'h000;
      r_s3_valid <= 1'b0;
      r_s3_rgb   <= 12'h000;
    end else begin
      r_s2_valid <= r_s1_valid;
      r_s2_rgb   <= w_blend_rgb;
      r_s3_valid <= r_s2_valid;
      r_s3_rgb   <= r_s2_rgb;
    end
  end

  assign bus.rgb_valid = r_s3_valid;
  assign bus.rgb       = r_s3_rgb;

endmodule

// File: tb/tb_vdp_blend_stage.sv
// Self-checking bench for vdp_blend_stage: directed palette/blend cases plus random
// traffic compared cycle by cycle against an arithmetic reference model.
module tb_vdp_blend_stage;

  typedef struct packed {
    logic       v;
    logic [7:0] pp;
    logic [4:0] pl;
    logic [7:0] mp;
    logic [4:0] ml;
    logic       be;
  } pix_t;

  typedef struct packed {
    logic        v;
    logic [11:0] rgb;
  } exp_t;

  logic clk;
  logic reset_n;
  vdp_blend_stage_if bus ();

  vdp_blend_stage dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          vcount = 0;
  logic [15:0] pal [256];
  pix_t        prev;
  exp_t        expq [$];
  logic [11:0] got;

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: look both indices up, blend with the masked alpha when alpha-over is on.
  function automatic exp_t model(input pix_t p);
    exp_t        e;
    logic [15:0] pc;
    logic [15:0] mc;
    int          a;
    int          pch;
    int          mch;
    pc = (p.pl != 5'd0) ? pal[p.pp] : pal[0];
    mc = pal[p.mp];
    a  = (p.be && p.ml != 5'd0) ? int'(mc[15:12]) : 0;
    e.v = p.v;
    for (int c = 0; c < 3; c++) begin
      pch = int'((pc >> (4 * c)) & 16'h000F);
      mch = int'((mc >> (4 * c)) & 16'h000F);
      e.rgb[4*c +: 4] = 4'((pch * (16 - a) + mch * a) / 16);
    end
    return e;
  endfunction

  task automatic rst_model();
    exp_t z;
    z = '0;
    expq.delete();
    expq.push_back(z);
    expq.push_back(z);
    prev = '0;
  endtask

  // One clock: advance the model at the edge, then compare the output 1 time unit later.
  task automatic tick();
    exp_t e;
    pix_t cur;
    @(posedge clk);
    cur.v  = bus.pixel_valid;
    cur.pp = bus.prioritized_pixel;
    cur.pl = bus.prioritized_layer;
    cur.mp = bus.prioritized_masked_pixel;
    cur.ml = bus.prioritized_masked_layer;
    cur.be = bus.blend_enable;
    expq.push_back(model(prev));
    if (bus.palette_write_en) pal[bus.palette_write_address] = bus.palette_write_data;
    prev = cur;
    #1;
    e = expq.pop_front();
    check_eq("rgb_valid", {15'd0, bus.rgb_valid}, {15'd0, e.v});
    if (e.v) check_eq("rgb", {4'd0, bus.rgb}, {4'd0, e.rgb});
    if (bus.rgb_valid) vcount++;
  endtask

  task automatic idle();
    bus.pixel_valid      = 1'b0;
    bus.palette_write_en = 1'b0;
  endtask

  task automatic wpal(input logic [7:0] addr, input logic [15:0] data);
    bus.palette_write_en      = 1'b1;
    bus.palette_write_address = addr;
    bus.palette_write_data    = data;
    tick();
    bus.palette_write_en = 1'b0;
  endtask

  task automatic pix(input logic [7:0] pp, input logic [4:0] pl, input logic [7:0] mp,
                     input logic [4:0] ml, input logic be, output logic [11:0] rgb_o);
    bus.pixel_valid              = 1'b1;
    bus.prioritized_pixel        = pp;
    bus.prioritized_layer        = pl;
    bus.prioritized_masked_pixel = mp;
    bus.prioritized_masked_layer = ml;
    bus.blend_enable             = be;
    tick();
    bus.pixel_valid = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    rgb_o = bus.rgb;
  endtask

  task automatic rand_pixel(input logic force_valid);
    bus.pixel_valid              = force_valid | 1'($urandom_range(0, 1));
    bus.prioritized_pixel        = 8'($urandom);
    bus.prioritized_layer        = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'(1 << $urandom_range(0, 4));
    bus.prioritized_masked_pixel = 8'($urandom);
    bus.prioritized_masked_layer = ($urandom_range(0, 2) == 0) ? 5'd0 : 5'(1 << $urandom_range(0, 4));
    bus.blend_enable             = 1'($urandom_range(0, 3) != 0);
    bus.palette_write_en         = ($urandom_range(0, 3) == 0);
    bus.palette_write_address    = 8'($urandom);
    bus.palette_write_data       = 16'($urandom);
  endtask

  initial begin
    reset_n = 1'b0;
    bus.pixel_valid = 1'b0;
    bus.prioritized_pixel = 8'd0;
    bus.prioritized_layer = 5'd0;
    bus.prioritized_masked_pixel = 8'd0;
    bus.prioritized_masked_layer = 5'd0;
    bus.blend_enable = 1'b0;
    bus.palette_write_en = 1'b0;
    bus.palette_write_address = 8'd0;
    bus.palette_write_data = 16'd0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_rgb", {4'd0, bus.rgb}, 16'h0000);
    check_eq("reset_valid", {15'd0, bus.rgb_valid}, 16'h0000);
    @(negedge clk);
    reset_n = 1'b1;
    rst_model();

    for (int i = 0; i < 256; i++) wpal(8'(i), 16'($urandom));

    // Reset then a single pixel on the tenth edge after release.
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_eq("rst2_rgb", {4'd0, bus.rgb}, 16'h0000);
    check_eq("rst2_valid", {15'd0, bus.rgb_valid}, 16'h0000);
    @(negedge clk);
    reset_n = 1'b1;
    rst_model();
    for (int i = 0; i < 9; i++) tick();
    bus.pixel_valid = 1'b1;
    bus.prioritized_layer = 5'b00001;
    tick();
    bus.pixel_valid = 1'b0;
    vcount = 0;
    for (int i = 0; i < 6; i++) tick();
    check_eq("latency_pulses", 16'(vcount), 16'd1);

    wpal(8'h21, 16'hF5A3);
    pix(8'h21, 5'b00010, 8'h00, 5'd0, 1'b1, got);
    check_eq("opaque", {4'd0, got}, 16'h05A3);

    wpal(8'h00, 16'h0123);
    pix(8'h77, 5'd0, 8'h00, 5'd0, 1'b0, got);
    check_eq("backdrop", {4'd0, got}, 16'h0123);

    wpal(8'h10, 16'h0F00);
    wpal(8'h20, 16'h800F);
    pix(8'h10, 5'b00001, 8'h20, 5'b00100, 1'b1, got);
    check_eq("blend_a8", {4'd0, got}, 16'h0707);
    pix(8'h10, 5'b00001, 8'h20, 5'b00100, 1'b0, got);
    check_eq("blend_off", {4'd0, got}, 16'h0F00);
    pix(8'h10, 5'b00001, 8'h20, 5'd0, 1'b1, got);
    check_eq("mask_none", {4'd0, got}, 16'h0F00);

    wpal(8'h30, 16'hF000);
    wpal(8'h31, 16'h0FFF);
    pix(8'h30, 5'b10000, 8'h31, 5'b01000, 1'b1, got);
    check_eq("alpha0", {4'd0, got}, 16'h0000);
    wpal(8'h31, 16'hFFFF);
    pix(8'h30, 5'b10000, 8'h31, 5'b01000, 1'b1, got);
    check_eq("alpha15", {4'd0, got}, 16'h0EEE);

    // Collision: the write lands on the same edge that S1 reads entry 0x40.
    wpal(8'h40, 16'hF222);
    bus.pixel_valid = 1'b1;
    bus.prioritized_pixel = 8'h40;
    bus.prioritized_layer = 5'b00001;
    bus.prioritized_masked_layer = 5'd0;
    tick();
    bus.palette_write_en = 1'b1;
    bus.palette_write_address = 8'h40;
    bus.palette_write_data = 16'hF111;
    tick();
    idle();
    tick();
    tick();
    check_eq("collide_old", {4'd0, bus.rgb}, 16'h0222);
    tick();
    check_eq("collide_new", {4'd0, bus.rgb}, 16'h0111);

    // Mid-stream reset discards everything in flight.
    for (int i = 0; i < 5; i++) begin
      rand_pixel(1'b1);
      tick();
    end
    idle();
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("midrst_valid", {15'd0, bus.rgb_valid}, 16'h0000);
    check_eq("midrst_rgb", {4'd0, bus.rgb}, 16'h0000);
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    rst_model();
    for (int i = 0; i < 4; i++) tick();

    vcount = 0;
    for (int i = 0; i < 256; i++) begin
      rand_pixel(1'b1);
      tick();
    end
    idle();
    for (int i = 0; i < 3; i++) tick();
    check_eq("burst_count", 16'(vcount), 16'd256);

    for (int i = 0; i < 400; i++) begin
      rand_pixel(1'b0);
      tick();
    end
    idle();
    for (int i = 0; i < 4; i++) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
